// File: rtl/ysyx_25030085_pc_gen.sv
// Program-counter generator for the multi-cycle NPC core: issues the PC to the IFU,
// waits for write-back, then selects the next PC and counts retired instructions.
module ysyx_25030085_pc_gen #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = 32'h8000_0000,
    parameter int               CNT_W     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_ready,
    input  logic             wb_valid,
    input  logic [1:0]       jump,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vec,
    input  logic             mret_valid,
    input  logic [XLEN-1:0]  mepc,
    output logic [XLEN-1:0]  pc_out,
    output logic             pc_valid,
    output logic             redirect,
    output logic             misalign_err,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALIGN4_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] ALIGN2_MASK = ~XLEN'(1);

    state_t           state, state_nxt;
    logic             wb_fire;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  target;
    logic             target_checked;
    logic             misalign;
    logic             retire;
    logic [XLEN-1:0]  pc_nxt;

    // NOTE: non-blocking assignments in clocked blocks so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:    state_nxt = REQ;
            REQ:     if (pc_ready) state_nxt = EXEC;
            EXEC:    if (wb_valid) state_nxt = REQ;
            default: state_nxt = BOOT;
        endcase
    end

    assign pc_valid = (state == REQ);
    assign wb_fire  = (state == EXEC) && wb_valid;
    assign pc_plus4 = pc_out + XLEN'(4);

    always_comb begin
        target         = pc_plus4;
        target_checked = 1'b0;
        unique case (jump)
            2'b01: begin
                target         = pc_out + imm;
                target_checked = 1'b1;
            end
            2'b10: begin
                target         = alu_result & ALIGN2_MASK;
                target_checked = 1'b1;
            end
            2'b11: begin
                if (br_taken) begin
                    target         = pc_out + imm;
                    target_checked = 1'b1;
                end
            end
            default: ;
        endcase

        // Trap and mret override the jump field entirely, including its alignment check.
        misalign = target_checked && (target[1:0] != 2'b00) && !trap_valid && !mret_valid;

        if (trap_valid)      pc_nxt = trap_vec & ALIGN4_MASK;
        else if (mret_valid) pc_nxt = mepc;
        else if (misalign)   pc_nxt = trap_vec & ALIGN4_MASK;
        else                 pc_nxt = target;

        retire = !trap_valid && !misalign;
    end

    // Pulses default low every cycle and are raised only on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out        <= RESET_VEC;
            redirect      <= 1'b0;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
            instret       <= '0;
        end else begin
            redirect     <= 1'b0;
            misalign_err <= 1'b0;
            if (wb_fire) begin
                pc_out   <= pc_nxt;
                redirect <= (pc_nxt != pc_plus4);
                if (misalign) begin
                    misalign_err  <= 1'b1;
                    misalign_addr <= target;
                end
                if (retire) instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25030085_pc_gen.sv
// Directed self-checking bench for ysyx_25030085_pc_gen: sequential flow, jumps,
// branches, trap/mret priority, misalignment, wrap-around, handshake stalls and reset.
module tb_ysyx_25030085_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_ready;
    logic        wb_valid;
    logic [1:0]  jump;
    logic        br_taken;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        mret_valid;
    logic [31:0] mepc;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        redirect;
    logic        misalign_err;
    logic [31:0] misalign_addr;
    logic [63:0] instret;

    int total = 0;
    int bad   = 0;

    ysyx_25030085_pc_gen dut (
        .clk          (clk),
        .rst          (rst),
        .pc_ready     (pc_ready),
        .wb_valid     (wb_valid),
        .jump         (jump),
        .br_taken     (br_taken),
        .imm          (imm),
        .alu_result   (alu_result),
        .trap_valid   (trap_valid),
        .trap_vec     (trap_vec),
        .mret_valid   (mret_valid),
        .mepc         (mepc),
        .pc_out       (pc_out),
        .pc_valid     (pc_valid),
        .redirect     (redirect),
        .misalign_err (misalign_err),
        .misalign_addr(misalign_addr),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // REQ -> EXEC: one cycle with pc_ready high.
    task automatic fetch();
        pc_ready = 1'b1;
        step();
        pc_ready = 1'b0;
    endtask

    // EXEC -> REQ: one cycle with wb_valid high and the given control inputs.
    task automatic retire(input logic [1:0] j, input logic br, input logic [31:0] im,
                          input logic [31:0] alu, input logic trp, input logic mrt);
        jump       = j;
        br_taken   = br;
        imm        = im;
        alu_result = alu;
        trap_valid = trp;
        mret_valid = mrt;
        wb_valid   = 1'b1;
        step();
        wb_valid   = 1'b0;
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        jump       = 2'b00;
        br_taken   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_ready = 1'b0; wb_valid = 1'b0; jump = 2'b00; br_taken = 1'b0;
        imm = '0; alu_result = '0; trap_valid = 1'b0; trap_vec = 32'h8000_1003;
        mret_valid = 1'b0; mepc = '0;

        step(); step();
        check("rst_pc", pc_out, 32'h8000_0000);
        check("rst_valid", pc_valid, 1'b0);
        check("rst_redirect", redirect, 1'b0);
        check("rst_mis_err", misalign_err, 1'b0);
        check("rst_mis_addr", misalign_addr, 32'h0);
        check("rst_instret", instret, 64'd0);

        rst = 1'b0;
        step();
        check("boot_valid", pc_valid, 1'b1);
        check("seq0_pc", pc_out, 32'h8000_0000);

        fetch();
        check("exec_valid", pc_valid, 1'b0);
        retire(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("seq1_pc", pc_out, 32'h8000_0004);
        check("seq1_valid", pc_valid, 1'b1);
        check("seq1_redirect", redirect, 1'b0);
        fetch(); retire(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("seq2_pc", pc_out, 32'h8000_0008);
        check("seq2_redirect", redirect, 1'b0);
        fetch(); retire(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("seq3_pc", pc_out, 32'h8000_000C);
        check("seq3_instret", instret, 64'd3);
        fetch(); retire(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("seq4_pc", pc_out, 32'h8000_0010);

        // JAL backwards, then JALR with bit 0 cleared
        fetch(); retire(2'b01, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0);
        check("jal_pc", pc_out, 32'h8000_0000);
        check("jal_redirect", redirect, 1'b1);
        check("jal_instret", instret, 64'd5);
        step();
        check("redirect_one_cycle", redirect, 1'b0);
        fetch(); retire(2'b10, 1'b0, 32'h0, 32'h8000_0101, 1'b0, 1'b0);
        check("jalr_pc", pc_out, 32'h8000_0100);
        check("jalr_redirect", redirect, 1'b1);

        // Branch taken and not taken from 8000_0020
        fetch(); retire(2'b01, 1'b0, 32'hFFFF_FF20, 32'h0, 1'b0, 1'b0);
        check("to20_pc", pc_out, 32'h8000_0020);
        fetch(); retire(2'b11, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
        check("br_taken_pc", pc_out, 32'h8000_0060);
        check("br_taken_redirect", redirect, 1'b1);
        fetch(); retire(2'b01, 1'b0, 32'hFFFF_FFC0, 32'h0, 1'b0, 1'b0);
        check("back20_pc", pc_out, 32'h8000_0020);
        fetch(); retire(2'b11, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
        check("br_nt_pc", pc_out, 32'h8000_0024);
        check("br_nt_redirect", redirect, 1'b0);
        check("br_nt_instret", instret, 64'd10);

        // Trap beats mret and a misaligned JAL; not counted as retired
        mepc = 32'h8000_0044;
        fetch(); retire(2'b01, 1'b0, 32'h2, 32'h0, 1'b1, 1'b1);
        check("trap_pc", pc_out, 32'h8000_1000);
        check("trap_instret", instret, 64'd10);
        check("trap_no_mis", misalign_err, 1'b0);
        check("trap_redirect", redirect, 1'b1);
        fetch(); retire(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("mret_pc", pc_out, 32'h8000_0044);
        check("mret_instret", instret, 64'd11);

        // Misaligned JAL and JALR targets divert to trap_vec & ~3
        fetch(); retire(2'b10, 1'b0, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        check("to0_pc", pc_out, 32'h8000_0000);
        fetch(); retire(2'b01, 1'b0, 32'h2, 32'h0, 1'b0, 1'b0);
        check("mis_jal_err", misalign_err, 1'b1);
        check("mis_jal_addr", misalign_addr, 32'h8000_0002);
        check("mis_jal_pc", pc_out, 32'h8000_1000);
        check("mis_jal_redirect", redirect, 1'b1);
        check("mis_jal_instret", instret, 64'd12);
        step();
        check("mis_err_one_cycle", misalign_err, 1'b0);
        check("mis_addr_held", misalign_addr, 32'h8000_0002);
        fetch(); retire(2'b10, 1'b0, 32'h0, 32'h8000_0007, 1'b0, 1'b0);
        check("mis_jalr_addr", misalign_addr, 32'h8000_0006);
        check("mis_jalr_pc", pc_out, 32'h8000_1000);
        check("mis_jalr_instret", instret, 64'd12);

        // Sequential wrap-around at the top of the address space
        fetch(); retire(2'b10, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        check("top_pc", pc_out, 32'hFFFF_FFFC);
        fetch(); retire(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("wrap_pc", pc_out, 32'h0000_0000);
        check("wrap_redirect", redirect, 1'b0);
        check("wrap_instret", instret, 64'd14);

        // Stall in REQ; wb_valid is ignored there
        wb_valid = 1'b1; jump = 2'b01; imm = 32'h100;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", pc_valid, 1'b1);
            check("stall_pc", pc_out, 32'h0000_0000);
        end
        wb_valid = 1'b0; jump = 2'b00;
        check("stall_instret", instret, 64'd14);

        // Stall in EXEC; pc_ready is ignored there
        fetch();
        pc_ready = 1'b1;
        step(); step();
        pc_ready = 1'b0;
        check("exec_stall_valid", pc_valid, 1'b0);
        check("exec_stall_pc", pc_out, 32'h0000_0000);

        // Asynchronous reset while in EXEC
        rst = 1'b1;
        #1;
        check("arst_pc", pc_out, 32'h8000_0000);
        check("arst_valid", pc_valid, 1'b0);
        check("arst_instret", instret, 64'd0);
        check("arst_mis_addr", misalign_addr, 32'h0);
        step();
        rst = 1'b0;
        step();
        check("arst_reboot_valid", pc_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
